// File: rtl/x_edge_decoder.sv
// x_edge_decoder: finds the propagating edge in each 32-bit delay-line tap
// snapshot and reports min/max/average edge position per window of 2^WIN_LOG2
// counted samples on a valid/ready output with sticky overflow.
// Optional bubble detection is built when X_EDGE_DECODER_BUBBLE_EN is defined.
module x_edge_decoder #(
    parameter int unsigned WIN_LOG2 = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    input  logic        i_clr,
    output logic        o_valid,
    output logic [4:0]  o_min,
    output logic [4:0]  o_max,
    output logic [4:0]  o_avg,
    output logic        o_ovf,
    output logic        o_bub
);

    localparam int unsigned CntW = WIN_LOG2 + 1;
    localparam int unsigned SumW = 5 + WIN_LOG2;
    localparam logic [CntW-1:0] LastCnt = CntW'((1 << WIN_LOG2) - 1);

    // Sample stage
    logic [31:0]     data_q;
    logic            en_q;
    // Stage 1
    logic [4:0]      pos_q;
    logic            v1_q;
    // Stage 2 accumulators
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      min_q, min_d;
    logic [4:0]      max_q, max_d;
    logic [SumW-1:0] sum_q, sum_d;
    // Result registers
    logic            valid_q, valid_d;
    logic [4:0]      rmin_q, rmin_d;
    logic [4:0]      rmax_q, rmax_d;
    logic [4:0]      ravg_q, ravg_d;
    logic            ovf_q, ovf_d;

    logic [30:0]     brk;
    logic [4:0]      pos_c;
    logic [4:0]      min_m, max_m;
    logic [SumW-1:0] sum_m;
    logic            done;

    // A break is where two adjacent taps agree; independent of launch polarity.
    assign brk = ~(data_q[30:0] ^ data_q[31:1]);

    // Priority-encode the lowest break; 31 when the chain never breaks.
    always_comb begin
        pos_c = 5'd31;
        for (int k = 30; k >= 0; k--) begin
            if (brk[k]) pos_c = 5'(k);
        end
    end

    // Merge the stage-1 position into the running accumulators.
    always_comb begin
        min_m = (pos_q < min_q) ? pos_q : min_q;
        max_m = (pos_q > max_q) ? pos_q : max_q;
        sum_m = sum_q + SumW'(pos_q);
        done  = v1_q && (cnt_q == LastCnt);
    end

`ifdef X_EDGE_DECODER_BUBBLE_EN
    logic bub1_q;
    logic wbub_q, wbub_d;
    logic rbub_q, rbub_d;
    logic bub_m;

    assign bub_m = wbub_q | bub1_q;

    // Bubble flag: more than one break in a single snapshot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bub1_q <= 1'b0;
            wbub_q <= 1'b0;
            rbub_q <= 1'b0;
        end else begin
            bub1_q <= ($countones(brk) > 1);
            wbub_q <= wbub_d;
            rbub_q <= rbub_d;
        end
    end

    // Window bubble accumulates with the counted samples; loads with the result.
    always_comb begin
        wbub_d = wbub_q;
        rbub_d = rbub_q;
        if (v1_q) wbub_d = done ? 1'b0 : bub_m;
        if (done && (!valid_q || i_ready)) rbub_d = bub_m;
    end

    assign o_bub = rbub_q;
`else
    assign o_bub = 1'b0;
`endif

    // Next-state for accumulators, result registers and overflow.
    always_comb begin
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        rmin_d  = rmin_q;
        rmax_d  = rmax_q;
        ravg_d  = ravg_q;
        ovf_d   = ovf_q;

        if (valid_q && i_ready) valid_d = 1'b0;
        if (i_clr) ovf_d = 1'b0;

        if (v1_q) begin
            if (done) begin
                cnt_d = '0;
                min_d = 5'd31;
                max_d = 5'd0;
                sum_d = '0;
                if (!valid_q || i_ready) begin
                    valid_d = 1'b1;
                    rmin_d  = min_m;
                    rmax_d  = max_m;
                    ravg_d  = 5'(sum_m >> WIN_LOG2);
                end else begin
                    // Held result is unaccepted; drop the new one. Set beats clear.
                    ovf_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                min_d = min_m;
                max_d = max_m;
                sum_d = sum_m;
            end
        end
    end

    // All pipeline and result state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            en_q    <= 1'b0;
            pos_q   <= 5'd0;
            v1_q    <= 1'b0;
            cnt_q   <= '0;
            min_q   <= 5'd31;
            max_q   <= 5'd0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            rmin_q  <= 5'd0;
            rmax_q  <= 5'd0;
            ravg_q  <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= i_data;
            en_q    <= i_en;
            pos_q   <= pos_c;
            v1_q    <= en_q;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            rmin_q  <= rmin_d;
            rmax_q  <= rmax_d;
            ravg_q  <= ravg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid = valid_q;
    assign o_min   = rmin_q;
    assign o_max   = rmax_q;
    assign o_avg   = ravg_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_x_edge_decoder.sv
// Directed self-checking bench for x_edge_decoder (WIN_LOG2 = 4).
module tb_x_edge_decoder;

    localparam logic [31:0] DPos3  = 32'hAAAA_AAA5; // first break at 3
    localparam logic [31:0] DNone  = 32'h5555_5555; // no break -> 31
    localparam logic [31:0] DBub   = 32'hAAAA_00A5; // pos 3 plus extra breaks

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_en = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_ready = 1'b0;
    logic        i_clr = 1'b0;
    logic        o_valid;
    logic [4:0]  o_min, o_max, o_avg;
    logic        o_ovf, o_bub;

    int n_tests = 0;
    int n_fail  = 0;

    x_edge_decoder #(.WIN_LOG2(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_data  (i_data),
        .i_ready (i_ready),
        .i_clr   (i_clr),
        .o_valid (o_valid),
        .o_min   (o_min),
        .o_max   (o_max),
        .o_avg   (o_avg),
        .o_ovf   (o_ovf),
        .o_bub   (o_bub)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present one counted sample across one sample edge.
    task automatic send(input logic [31:0] d);
        i_en   = 1'b1;
        i_data = d;
        step();
        i_en   = 1'b0;
    endtask

    task automatic send_n(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) send(d);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int t = 0;
        while (!o_valid && t < budget) begin
            step();
            t++;
        end
        check_eq(tag, o_valid, 1);
    endtask

    task automatic accept();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_min", o_min, 0);
        check_eq("rst_max", o_max, 0);
        check_eq("rst_avg", o_avg, 0);
        check_eq("rst_ovf", o_ovf, 0);
        check_eq("rst_bub", o_bub, 0);

        // Uniform window, exact latency
        send_n(DPos3, 16);
        check_eq("t1_lat0", o_valid, 0);
        step();
        check_eq("t1_lat1", o_valid, 0);
        step();
        check_eq("t1_lat2", o_valid, 1);
        check_eq("t1_min", o_min, 3);
        check_eq("t1_max", o_max, 3);
        check_eq("t1_avg", o_avg, 3);
        check_eq("t1_ovf", o_ovf, 0);
        accept();
        check_eq("t1_xfer", o_valid, 0);

        // Interleaved pos 3 / pos 31
        for (int i = 0; i < 8; i++) begin
            send(DPos3);
            send(DNone);
        end
        wait_valid("t2_valid", 5);
        check_eq("t2_min", o_min, 3);
        check_eq("t2_max", o_max, 31);
        check_eq("t2_avg", o_avg, 17);
        accept();
        check_eq("t2_xfer", o_valid, 0);

        // Overflow: two windows with no acceptance
        send_n(DPos3, 16);
        send_n(DNone, 16);
        step();
        step();
        step();
        check_eq("t3_valid", o_valid, 1);
        check_eq("t3_min", o_min, 3);
        check_eq("t3_max", o_max, 3);
        check_eq("t3_avg", o_avg, 3);
        check_eq("t3_ovf", o_ovf, 1);
        accept();
        check_eq("t3_xfer", o_valid, 0);
        step();
        check_eq("t3_single", o_valid, 0);
        check_eq("t3_ovf_held", o_ovf, 1);
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        check_eq("t3_clr", o_ovf, 0);

        // Gap in i_en keeps the partial window
        send_n(DPos3, 10);
        for (int i = 0; i < 5; i++) step();
        check_eq("t4_gap", o_valid, 0);
        send_n(DPos3, 6);
        check_eq("t4_lat0", o_valid, 0);
        step();
        check_eq("t4_lat1", o_valid, 0);
        step();
        check_eq("t4_lat2", o_valid, 1);
        check_eq("t4_avg", o_avg, 3);
        accept();
        check_eq("t4_xfer", o_valid, 0);

        // Reset mid-window discards the partial window
        send_n(DPos3, 10);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        send_n(DPos3, 15);
        step();
        step();
        step();
        check_eq("t4r_nores", o_valid, 0);
        send(DPos3);
        step();
        step();
        check_eq("t4r_valid", o_valid, 1);
        check_eq("t4r_avg", o_avg, 3);
        accept();
        check_eq("t4r_xfer", o_valid, 0);

        // Transfer and new completion in the same cycle
        send_n(DPos3, 16);
        send_n(DNone, 16);
        check_eq("t5_held", o_valid, 1);
        step();
        check_eq("t5_min_old", o_min, 3);
        i_ready = 1'b1;
        step();
        check_eq("t5_valid", o_valid, 1);
        check_eq("t5_min", o_min, 31);
        check_eq("t5_max", o_max, 31);
        check_eq("t5_avg", o_avg, 31);
        check_eq("t5_ovf", o_ovf, 0);
        step();
        i_ready = 1'b0;
        check_eq("t5_xfer", o_valid, 0);

        // Bubble window then a clean window
        send_n(DPos3, 5);
        send(DBub);
        send_n(DPos3, 10);
        wait_valid("t6_valid", 5);
`ifdef X_EDGE_DECODER_BUBBLE_EN
        check_eq("t6_bub", o_bub, 1);
`else
        check_eq("t6_bub", o_bub, 0);
`endif
        check_eq("t6_min", o_min, 3);
        check_eq("t6_max", o_max, 3);
        accept();
        send_n(DPos3, 16);
        wait_valid("t6c_valid", 5);
        check_eq("t6c_bub", o_bub, 0);
        check_eq("t6c_avg", o_avg, 3);
        accept();
        check_eq("t6c_xfer", o_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
